// File: rtl/sipo_deser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sipo_deser_if                                                 |
// | Purpose  : Bundles the serial input, parallel output handshake and the   |
// |            status flags of sipo_deser.                                   |
// | Ports    : sin, sin_valid     - serial bit (LSB first) and its qualifier  |
// |            out_ready          - consumer accepts pout this cycle         |
// |            pout, pout_valid   - assembled word and its valid flag        |
// |            busy               - a frame is partially received            |
// |            overrun            - sticky: a completed frame was dropped    |
// |            parity_err         - sticky: parity bit mismatch              |
// | Modports : master - serial source / word consumer side                   |
// |            slave  - deserializer side                                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface sipo_deser_if #(
  parameter int WIDTH = 4
) ();

  logic             sin;
  logic             sin_valid;
  logic             out_ready;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output sin,
    output sin_valid,
    output out_ready,
    input  pout,
    input  pout_valid,
    input  busy,
    input  overrun,
    input  parity_err
  );

  modport slave (
    input  sin,
    input  sin_valid,
    input  out_ready,
    output pout,
    output pout_valid,
    output busy,
    output overrun,
    output parity_err
  );

endinterface
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sipo_deser                                                    |
// | Purpose  : Serial-in / parallel-out deserializer. Collects WIDTH data    |
// |            bits (LSB first) into a word, presents it with a valid/ready  |
// |            handshake and flags dropped frames.                           |
// | Params   : WIDTH - data bits per frame (>= 2)                            |
// | Macro    : SIPO_DESER_PARITY_EN - when defined each frame carries one    |
// |            extra even-parity bit after the data bits; a mismatch sets    |
// |            the sticky parity_err flag, the word is delivered anyway.     |
// | Ports    : clk  - clock, rising edge                                     |
// |            clr  - synchronous active-high reset                          |
// |            bus  - sipo_deser_if.slave (sin, sin_valid, out_ready, pout,  |
// |                   pout_valid, busy, overrun, parity_err)                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  sipo_deser_if.slave bus
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             overrun_q, overrun_d;

  logic             frame_done;
  logic             data_bit;
  logic [WIDTH-1:0] frame_word;

`ifdef SIPO_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`else
  // The oldest bit falls out of the register as the word is taken from the
  // shifted value, so the register LSB is never read in this build.
  logic             unused_sr_lsb;
  assign unused_sr_lsb = sr_q[0];
`endif

  always_comb begin
    frame_done = bus.sin_valid && (cnt_q == LAST_CNT);

    cnt_d = cnt_q;
    if (bus.sin_valid) begin
      cnt_d = frame_done ? '0 : cnt_q + CNT_W'(1);
    end
    state_d = (cnt_d == '0) ? IDLE : SHIFT;

`ifdef SIPO_DESER_PARITY_EN
    // The final (parity) bit never enters the register; the data word is
    // already complete in sr_q when it arrives.
    data_bit   = (cnt_q != LAST_CNT);
    frame_word = sr_q;
`else
    // The final bit completes the word on the same edge, so the word is the
    // shift-register value after this bit is shifted in.
    data_bit   = 1'b1;
    frame_word = {bus.sin, sr_q[WIDTH-1:1]};
`endif

    sr_d = sr_q;
    if (bus.sin_valid && data_bit) begin
      sr_d = {bus.sin, sr_q[WIDTH-1:1]};
    end

    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    overrun_d    = overrun_q;
    if (frame_done) begin
      if (!pout_valid_q || bus.out_ready) begin
        pout_d       = frame_word;
        pout_valid_d = 1'b1;
      end else begin
        // Consumer still holds the previous word: keep it, drop the new one.
        overrun_d = 1'b1;
      end
    end else if (pout_valid_q && bus.out_ready) begin
      pout_valid_d = 1'b0;
    end

`ifdef SIPO_DESER_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even count of ones.
    parity_err_d = parity_err_q | (frame_done && ((^sr_q) != bus.sin));
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SIPO_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.overrun    = overrun_q;
`ifdef SIPO_DESER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sipo_deser                                                 |
// | Purpose  : Self-checking bench for sipo_deser (WIDTH=4). Directed frames |
// |            with literal expectations followed by randomized traffic      |
// |            compared every cycle against a behavioural frame model.       |
// | Macro    : SIPO_DESER_PARITY_EN - adds the parity-bit scenarios          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sipo_deser;

  localparam int WIDTH = 4;
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   check_en = 1'b0;

  sipo_deser_if #(.WIDTH(WIDTH)) bus ();

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model: bits are placed into the word by their position in
  // the frame; a finished word is offered to the consumer slot.
  // ---------------------------------------------------------------------
  int               m_cnt   = 0;
  logic [WIDTH-1:0] m_acc   = '0;
  logic [WIDTH-1:0] m_pout  = '0;
  logic             m_valid = 1'b0;
  logic             m_ovr   = 1'b0;
  logic             m_perr  = 1'b0;

  always @(posedge clk) begin : model
    logic             done;
    logic [WIDTH-1:0] word;
    done = 1'b0;
    word = '0;
    if (clr) begin
      m_cnt   = 0;
      m_acc   = '0;
      m_pout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else begin
      if (bus.sin_valid) begin
        if (m_cnt < WIDTH) begin
          m_acc[m_cnt] = bus.sin;
        end else if ((($countones(m_acc) + int'(bus.sin)) % 2) != 0) begin
          m_perr = 1'b1;
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == FRAME) begin
          done  = 1'b1;
          word  = m_acc;
          m_cnt = 0;
          m_acc = '0;
        end
      end
      if (done) begin
        if (!m_valid || bus.out_ready) begin
          m_pout  = word;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs change only on posedge; compare on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cmp_pout",       32'(bus.pout),       32'(m_pout));
      check("cmp_pout_valid", 32'(bus.pout_valid), 32'(m_valid));
      check("cmp_busy",       32'(bus.busy),       32'(m_cnt != 0));
      check("cmp_overrun",    32'(bus.overrun),    32'(m_ovr));
      check("cmp_parity_err", 32'(bus.parity_err), 32'(m_perr));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int i);
    if (i < WIDTH) return w[i];
    return ^w;
  endfunction

  task automatic drive(input logic s, input logic v, input logic r);
    @(negedge clk);
    bus.sin       = s;
    bus.sin_valid = v;
    bus.out_ready = r;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input logic r);
    for (int i = 0; i < FRAME; i++) begin
      drive(frame_bit(w, i), 1'b1, r);
      repeat (gap) drive(1'b0, 1'b0, r);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr           = 1'b1;
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    clr           = 1'b1;
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_en = 1'b1;

    // Reset state
    do_reset();
    check("rst_pout",       32'(bus.pout),       32'h0);
    check("rst_pout_valid", 32'(bus.pout_valid), 32'h0);
    check("rst_busy",       32'(bus.busy),       32'h0);
    check("rst_overrun",    32'(bus.overrun),    32'h0);
    check("rst_parity_err", 32'(bus.parity_err), 32'h0);

    // Consecutive bits 1,0,1,1 -> 4'hD
    send_frame(4'hD, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("d_pout",       32'(bus.pout),       32'hD);
    check("d_pout_valid", 32'(bus.pout_valid), 32'h1);
    check("d_busy",       32'(bus.busy),       32'h0);
    check("d_model_pout", 32'(m_pout),         32'hD);

    // Same word with 3-cycle gaps; busy holds through the gaps
    do_reset();
    for (int i = 0; i < FRAME; i++) begin
      drive(frame_bit(4'hD, i), 1'b1, 1'b0);
      for (int g = 0; g < 3; g++) begin
        drive(1'b0, 1'b0, 1'b0);
        if (g == 0) check("gap_busy", 32'(bus.busy), 32'(i < FRAME - 1));
      end
    end
    check("gap_pout",       32'(bus.pout),       32'hD);
    check("gap_pout_valid", 32'(bus.pout_valid), 32'h1);

    // Overrun: 4'hA held, 4'h5 dropped
    do_reset();
    send_frame(4'hA, 0, 1'b0);
    send_frame(4'h5, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("ovr_pout",        32'(bus.pout),       32'hA);
    check("ovr_pout_valid",  32'(bus.pout_valid), 32'h1);
    check("ovr_overrun",     32'(bus.overrun),    32'h1);
    check("ovr_model_flag",  32'(m_ovr),          32'h1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("ovr_consumed",    32'(bus.pout_valid), 32'h0);
    check("ovr_sticky",      32'(bus.overrun),    32'h1);

    // Back-to-back 4'h3 then 4'hC with out_ready held high
    do_reset();
    send_frame(4'h3, 0, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      drive(frame_bit(4'hC, i), 1'b1, 1'b1);
      if (i == 0) begin
        check("b2b_first_pout",  32'(bus.pout),       32'h3);
        check("b2b_first_valid", 32'(bus.pout_valid), 32'h1);
      end
      if (i == 1) check("b2b_first_gone", 32'(bus.pout_valid), 32'h0);
    end
    drive(1'b0, 1'b0, 1'b1);
    check("b2b_second_pout",  32'(bus.pout),       32'hC);
    check("b2b_second_valid", 32'(bus.pout_valid), 32'h1);
    check("b2b_model_pout",   32'(m_pout),         32'hC);
    drive(1'b0, 1'b0, 1'b1);
    check("b2b_second_gone",  32'(bus.pout_valid), 32'h0);
    check("b2b_overrun",      32'(bus.overrun),    32'h0);

    // clr mid-frame discards the partial frame
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clr           = 1'b1;
    bus.sin       = 1'b1;
    bus.sin_valid = 1'b1;
    @(negedge clk);
    clr           = 1'b0;
    bus.sin_valid = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'h0);
    send_frame(4'hF, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("clr_pout",       32'(bus.pout),       32'hF);
    check("clr_pout_valid", 32'(bus.pout_valid), 32'h1);

`ifdef SIPO_DESER_PARITY_EN
    begin : parity_cases
      logic [FRAME-1:0] bits;
      // data 1,0,0,0 with parity 0 -> odd count of ones, error
      do_reset();
      bits = 5'b00001;
      for (int i = 0; i < FRAME; i++) drive(bits[i], 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check("par_bad_pout", 32'(bus.pout),       32'h1);
      check("par_bad_err",  32'(bus.parity_err), 32'h1);
      check("par_model",    32'(m_perr),         32'h1);
      // data 1,1,0,0 with parity 0 -> even, no error
      do_reset();
      check("par_clr_err", 32'(bus.parity_err), 32'h0);
      bits = 5'b00011;
      for (int i = 0; i < FRAME; i++) drive(bits[i], 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      check("par_good_pout", 32'(bus.pout),       32'h3);
      check("par_good_err",  32'(bus.parity_err), 32'h0);
    end
`endif

    // Randomized traffic with three consumer-readiness profiles
    do_reset();
    for (int c = 0; c < 4500; c++) begin
      @(negedge clk);
      clr           = ($urandom_range(0, 299) == 0);
      bus.sin       = 1'($urandom_range(0, 1));
      bus.sin_valid = ($urandom_range(0, 3) != 0);
      case (c / 1500)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = ($urandom_range(0, 7) == 0);
      endcase
    end
    @(negedge clk);
    clr           = 1'b0;
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of data bits per frame (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sin, input, 1 bit: serial data, LSB first.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: sin is sampled on a rising edge only when this is 1.
REQ-006 The block SHALL have port out_ready, input, 1 bit: the consumer accepts pout this cycle.
REQ-007 The block SHALL have port pout, output, WIDTH bits: assembled parallel word.
REQ-008 The block SHALL have port pout_valid, output, 1 bit: pout holds an unconsumed word.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is partially received.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a completed frame was dropped.
REQ-011 The block SHALL have port parity_err, output, 1 bit: sticky parity-failure flag (see Configuration).

Function
REQ-012 Bits SHALL enter a WIDTH-bit shift register at the MSB and shift toward bit 0 (sr <= {sin, sr[WIDTH-1:1]}), so the first bit received lands in pout[0].
REQ-013 A bit counter SHALL count accepted bits from 0 to FRAME-1 and wrap to 0. FRAME is WIDTH, or WIDTH+1 with the parity option.
REQ-014 State SHALL be IDLE when the counter is 0 and SHIFT otherwise. busy SHALL be 1 exactly in SHIFT.
REQ-015 Cycles with sin_valid=0 SHALL leave the counter and shift register unchanged. Gaps of any length inside a frame SHALL be allowed.
REQ-016 On the edge that samples the final bit of a frame, the frame SHALL complete. The assembled word SHALL appear on pout, with pout_valid=1, in the next cycle (latency 1 edge from the last bit).
REQ-017 pout and pout_valid SHALL stay stable while pout_valid=1 and out_ready=0.
REQ-018 pout_valid=1 with out_ready=1 SHALL clear pout_valid on that edge, unless a frame completes on the same edge.
REQ-019 If a frame completes on the same edge as out_ready=1, the new word SHALL load and pout_valid SHALL remain 1. Back-to-back frames SHALL lose no bits.
REQ-020 If a frame completes while pout_valid=1 and out_ready=0, the new word SHALL be dropped, pout SHALL keep the old word, and overrun SHALL be set.
REQ-021 out_ready while pout_valid=0 SHALL have no effect.
REQ-022 overrun and parity_err SHALL be cleared only by clr.

Reset
REQ-023 clr=1 at a rising edge SHALL set the following, overriding all other inputs:
- counter=0, shift register=0
- pout=0, pout_valid=0
- busy=0, overrun=0, parity_err=0
REQ-024 clr asserted mid-frame SHALL discard the partial frame. The next accepted bit SHALL be bit 0 of a new frame.
REQ-025 clr SHALL discard an unconsumed pout word.

Configuration
REQ-026 Macro SIPO_DESER_PARITY_EN, when defined, SHALL set FRAME=WIDTH+1. The final bit is an even-parity bit over the WIDTH data bits.
REQ-027 With SIPO_DESER_PARITY_EN defined, the parity bit SHALL NOT enter the shift register. On a parity mismatch, parity_err SHALL be set and the word SHALL still be delivered.
REQ-028 Without SIPO_DESER_PARITY_EN, FRAME=WIDTH and parity_err SHALL be tied to 0.

Verification (WIDTH=4, macro undefined unless stated)
REQ-029 Send sin=1,0,1,1 with sin_valid=1 on 4 consecutive edges, out_ready=0 -> next cycle pout=4'hD, pout_valid=1, busy=0.
REQ-030 Send the same 4 bits with sin_valid=0 gaps of 3 cycles between bits -> pout=4'hD, busy=1 from the first bit until the last bit.
REQ-031 Send frame 4'hA, hold out_ready=0, then send frame 4'h5 -> pout stays 4'hA and overrun=1. Then pulse out_ready -> pout_valid=0.
REQ-032 Send two back-to-back frames 4'h3 then 4'hC with out_ready=1 throughout -> pout is 4'h3 then 4'hC, each valid for 1 cycle, overrun=0.
REQ-033 Send 2 bits, assert clr for 1 cycle, then send 1,1,1,1 -> pout=4'hF, pout_valid=1.
REQ-034 With SIPO_DESER_PARITY_EN defined, send data 1,0,0,0 then parity bit 0 -> pout=4'h1, parity_err=1. Data 1,1,0,0 with parity 0 -> parity_err stays 0 after clr.
